// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command path.
// Holds the transmitter state encoding, the default divider/gap settings and
// the frame format (bit order and SPI mode) that spi_controller also imports.
package spi_pkg;

  localparam int unsigned CLK_DIV_DEFAULT = 2;
  localparam int unsigned CS_GAP_DEFAULT  = 4;

  // Frame format: MSB first, mode 0 (CPOL=0, CPHA=0).
  localparam bit          MSB_FIRST = 1'b1;
  localparam int unsigned SPI_MODE  = 0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    HOLD,
    GAP
  } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider for the SPI transmitter.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   en    - count while high; the count restarts from zero whenever en is low
//   tick  - one-cycle pulse every CLK_DIV enabled cycles
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_command_tx.sv
// SPI mode-0 command transmitter fed from a first-word-fall-through FIFO.
// Bytes are shifted out MSB first; back-to-back bytes share one chip-select
// window, otherwise chip select is held briefly and then kept high for at
// least CS_GAP cycles between frames.
// Ports:
//   clk, rst_n      - system clock, synchronous active-low reset
//   command_rddata  - FIFO head byte (valid while command_empty is low)
//   command_empty   - FIFO empty flag
//   command_pull    - one-cycle FIFO pop strobe
//   spi_clk         - SPI clock, idle low
//   spi_cs_n        - active-low chip select
//   spi_mosi        - serial data out
//   busy            - high whenever the FSM is not in IDLE
module spi_command_tx
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT,
  parameter int unsigned CS_GAP  = CS_GAP_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] command_rddata,
  input  logic       command_empty,
  output logic       command_pull,
  output logic       spi_clk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  output logic       busy
);

  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  spi_state_e state;
  logic [6:0] shreg;      // bits still to send after the one on spi_mosi
  logic [2:0] bit_cnt;    // index of the bit currently on spi_mosi
  logic [7:0] gap_cnt;
  logic       hold_half;
  logic       div_en;
  logic       tick;
  logic       last_fall;

  assign div_en = (state == SETUP) || (state == LOW) ||
                  (state == HIGH)  || (state == HOLD);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (div_en),
    .tick (tick)
  );

  // Falling edge that ends bit 0: the only point where a burst can continue.
  assign last_fall = (state == HIGH) && tick && (bit_cnt == 3'd0);

  // Pop in the same cycle the head byte is latched; gated by rst_n so no byte
  // is consumed while the FSM is being reset.
  assign command_pull = rst_n && !command_empty && ((state == IDLE) || last_fall);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      hold_half <= 1'b0;
      spi_clk   <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_mosi  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!command_empty) begin
            shreg    <= command_rddata[6:0];
            spi_mosi <= command_rddata[7];
            bit_cnt  <= 3'd7;
            spi_cs_n <= 1'b0;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            spi_clk <= 1'b1;
            state   <= HIGH;
          end
        end
        HIGH: begin
          if (tick) begin
            spi_clk <= 1'b0;
            if (bit_cnt != 3'd0) begin
              spi_mosi <= shreg[6];
              shreg    <= {shreg[5:0], 1'b0};
              bit_cnt  <= bit_cnt - 3'd1;
              state    <= LOW;
            end else if (!command_empty) begin
              // Burst: next byte's bit 7 takes the low phase directly.
              spi_mosi <= command_rddata[7];
              shreg    <= command_rddata[6:0];
              bit_cnt  <= bit_cnt - 3'd1;
              state    <= LOW;
            end else begin
              hold_half <= 1'b0;
              state     <= HOLD;
            end
          end
        end
        LOW: begin
          if (tick) begin
            spi_clk <= 1'b1;
            state   <= HIGH;
          end
        end
        HOLD: begin
          // First half completes bit 0's low phase, second half is the
          // CLK_DIV chip-select hold before release.
          if (tick) begin
            if (!hold_half) begin
              hold_half <= 1'b1;
            end else begin
              spi_cs_n <= 1'b1;
              spi_mosi <= 1'b0;
              gap_cnt  <= '0;
              state    <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_command_tx.sv
// Directed bench for spi_command_tx: one instance at CLK_DIV=2 and one at
// CLK_DIV=1, each fed by a small FIFO model and watched by a receiver.
module tb_spi_command_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rddata [2];
  logic       empty  [2];
  logic       pull   [2];
  logic       sclk   [2];
  logic       csn    [2];
  logic       mosi   [2];
  logic       busy   [2];

  always #5 clk = ~clk;

  spi_command_tx #(.CLK_DIV(2), .CS_GAP(4)) dut (
    .clk(clk), .rst_n(rst_n), .command_rddata(rddata[0]), .command_empty(empty[0]),
    .command_pull(pull[0]), .spi_clk(sclk[0]), .spi_cs_n(csn[0]),
    .spi_mosi(mosi[0]), .busy(busy[0])
  );

  spi_command_tx #(.CLK_DIV(1), .CS_GAP(4)) dut_fast (
    .clk(clk), .rst_n(rst_n), .command_rddata(rddata[1]), .command_empty(empty[1]),
    .command_pull(pull[1]), .spi_clk(sclk[1]), .spi_cs_n(csn[1]),
    .spi_mosi(mosi[1]), .busy(busy[1])
  );

  // FIFO models: stimulus writes mem/wp, the pop process owns rp.
  logic [7:0] mem [2][16];
  logic [3:0] wp  [2] = '{4'd0, 4'd0};
  logic [3:0] rp  [2] = '{4'd0, 4'd0};

  assign empty[0]  = (wp[0] == rp[0]);
  assign empty[1]  = (wp[1] == rp[1]);
  assign rddata[0] = mem[0][rp[0]];
  assign rddata[1] = mem[1][rp[1]];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (pull[i] && !empty[i]) rp[i] <= rp[i] + 4'd1;
  end

  // Receiver / protocol monitor, sampling on the falling clk edge.
  int  cyc = 0;
  bit  prev_clk [2] = '{1'b0, 1'b0};
  bit  prev_cs  [2] = '{1'b1, 1'b1};
  bit  prev_mosi[2] = '{1'b0, 1'b0};
  bit  prev_busy[2] = '{1'b0, 1'b0};
  bit  rise_seen[2] = '{1'b0, 1'b0};
  int  pulls[2], pull_bad[2], proto_bad[2], cs_falls[2], edges[2], space_bad[2];
  int  fall_t[2], rise_t[2], low_len[2], last_gap[2], busy_fall_t[2];
  int  first_edge_t[2], last_edge_t[2], win_edges[2], nbits[2], rx_n[2];
  logic [7:0] sh[2];
  logic [7:0] rx_buf[2][32];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      prev_clk[i]  <= sclk[i];
      prev_cs[i]   <= csn[i];
      prev_mosi[i] <= mosi[i];
      prev_busy[i] <= busy[i];
      if (pull[i]) pulls[i] <= pulls[i] + 1;
      if (pull[i] && empty[i]) pull_bad[i] <= pull_bad[i] + 1;
      if ((csn[i] && mosi[i]) || (sclk[i] && (mosi[i] != prev_mosi[i])))
        proto_bad[i] <= proto_bad[i] + 1;
      if (!csn[i] && prev_cs[i]) begin
        cs_falls[i]  <= cs_falls[i] + 1;
        fall_t[i]    <= cyc;
        nbits[i]     <= 0;
        win_edges[i] <= 0;
        if (rise_seen[i]) last_gap[i] <= cyc - rise_t[i];
      end
      if (csn[i] && !prev_cs[i]) begin
        rise_t[i]    <= cyc;
        rise_seen[i] <= 1'b1;
        low_len[i]   <= cyc - fall_t[i];
      end
      if (!busy[i] && prev_busy[i]) busy_fall_t[i] <= cyc;
      if (sclk[i] && !prev_clk[i]) begin
        edges[i] <= edges[i] + 1;
        if (win_edges[i] == 0) first_edge_t[i] <= cyc;
        else if ((cyc - last_edge_t[i]) != ((i == 0) ? 4 : 2)) space_bad[i] <= space_bad[i] + 1;
        win_edges[i]   <= win_edges[i] + 1;
        last_edge_t[i] <= cyc;
        if (nbits[i] == 7) begin
          rx_buf[i][rx_n[i] % 32] <= {sh[i][6:0], mosi[i]};
          rx_n[i]  <= rx_n[i] + 1;
          nbits[i] <= 0;
        end else begin
          sh[i]    <= {sh[i][6:0], mosi[i]};
          nbits[i] <= nbits[i] + 1;
        end
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    mem[i][wp[i]] = b;
    wp[i] = wp[i] + 4'd1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for busy to rise and then fall; an expired budget counts as a failure.
  task automatic wait_done(input int i);
    int k;
    for (k = 0; k < 20 && !busy[i]; k++) step();
    if (!busy[i]) check_eq("timeout_busy_rise", 0, 1);
    for (k = 0; k < 2000 && busy[i]; k++) step();
    if (busy[i]) check_eq("timeout_busy_fall", 0, 1);
    step();
    step();
  endtask

  int s_pulls, s_edges, s_falls, s_rx, s_space, k;

  task automatic snap(input int i);
    s_pulls = pulls[i];
    s_edges = edges[i];
    s_falls = cs_falls[i];
    s_rx    = rx_n[i];
    s_space = space_bad[i];
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cs_n", csn[0], 1);
    check_eq("rst_spi_clk", sclk[0], 0);
    check_eq("rst_mosi", mosi[0], 0);
    check_eq("rst_busy", busy[0], 0);
    check_eq("rst_pull", pull[0], 0);
    rst_n = 1'b1;

    // Single byte 0xA5.
    snap(0);
    push(0, 8'hA5);
    wait_done(0);
    check_eq("single_byte", rx_buf[0][s_rx % 32], 8'hA5);
    check_eq("single_nbytes", rx_n[0] - s_rx, 1);
    check_eq("single_edges", edges[0] - s_edges, 8);
    check_eq("single_spacing", space_bad[0] - s_space, 0);
    check_eq("single_pulls", pulls[0] - s_pulls, 1);
    check_eq("single_frames", cs_falls[0] - s_falls, 1);
    check_eq("single_cs_low", low_len[0], 36);
    check_eq("single_setup", first_edge_t[0] - fall_t[0], 2);
    check_eq("single_tail", rise_t[0] - last_edge_t[0], 6);
    check_eq("single_busy_gap", busy_fall_t[0] - rise_t[0], 4);

    // Burst of three bytes.
    snap(0);
    push(0, 8'h01);
    push(0, 8'h80);
    push(0, 8'hFF);
    wait_done(0);
    check_eq("burst_frames", cs_falls[0] - s_falls, 1);
    check_eq("burst_edges", edges[0] - s_edges, 24);
    check_eq("burst_spacing", space_bad[0] - s_space, 0);
    check_eq("burst_pulls", pulls[0] - s_pulls, 3);
    check_eq("burst_cs_low", low_len[0], 100);
    check_eq("burst_b0", rx_buf[0][s_rx % 32], 8'h01);
    check_eq("burst_b1", rx_buf[0][(s_rx + 1) % 32], 8'h80);
    check_eq("burst_b2", rx_buf[0][(s_rx + 2) % 32], 8'hFF);

    // Late arrival during HOLD.
    snap(0);
    push(0, 8'h11);
    for (k = 0; k < 500 && (edges[0] - s_edges) < 8; k++) step();
    for (k = 0; k < 20 && sclk[0]; k++) step();
    check_eq("late_in_hold", (edges[0] - s_edges == 8) && !sclk[0] && !csn[0], 1);
    push(0, 8'h3C);
    wait_done(0);
    wait_done(0);
    check_eq("late_frames", cs_falls[0] - s_falls, 2);
    check_eq("late_gap_min", last_gap[0] >= 4, 1);
    check_eq("late_pulls", pulls[0] - s_pulls, 2);
    check_eq("late_b0", rx_buf[0][s_rx % 32], 8'h11);
    check_eq("late_b1", rx_buf[0][(s_rx + 1) % 32], 8'h3C);

    // Reset mid-byte.
    snap(0);
    push(0, 8'hC3);
    push(0, 8'h5A);
    for (k = 0; k < 500 && (edges[0] - s_edges) < 3; k++) step();
    rst_n = 1'b0;
    step();
    check_eq("midrst_cs_n", csn[0], 1);
    check_eq("midrst_spi_clk", sclk[0], 0);
    check_eq("midrst_mosi", mosi[0], 0);
    check_eq("midrst_busy", busy[0], 0);
    check_eq("midrst_pull", pull[0], 0);
    step();
    rst_n = 1'b1;
    wait_done(0);
    check_eq("midrst_nbytes", rx_n[0] - s_rx, 1);
    check_eq("midrst_byte", rx_buf[0][s_rx % 32], 8'h5A);
    check_eq("midrst_pulls", pulls[0] - s_pulls, 2);
    check_eq("midrst_fifo_empty", empty[0], 1);

    // CLK_DIV=1 corner.
    snap(1);
    push(1, 8'h55);
    wait_done(1);
    check_eq("fast_byte", rx_buf[1][s_rx % 32], 8'h55);
    check_eq("fast_edges", edges[1] - s_edges, 8);
    check_eq("fast_spacing", space_bad[1] - s_space, 0);
    check_eq("fast_pulls", pulls[1] - s_pulls, 1);
    check_eq("fast_cs_low", low_len[1], 18);

    check_eq("pull_while_empty_0", pull_bad[0], 0);
    check_eq("pull_while_empty_1", pull_bad[1], 0);
    check_eq("mode0_protocol_0", proto_bad[0], 0);
    check_eq("mode0_protocol_1", proto_bad[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
